// File: rtl/wb_rr_intercon.sv
// Wishbone shared-bus interconnect: NM masters, NS slaves, round-robin grant
// held for a whole bus cycle, address-decoded slave select (addr[31:28]),
// and a slave-response watchdog that turns a stall into a one-cycle error.
module wb_rr_intercon #(
  parameter int NM = 4,
  parameter int NS = 8,
  parameter int TO = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [4*NM-1:0]   m_sel_i,
  input  logic [32*NM-1:0]  m_addr_i,
  input  logic [32*NM-1:0]  m_data_i,
  output logic [31:0]       m_data_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  output logic [NS-1:0]     s_cyc_o,
  output logic [NS-1:0]     s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [31:0]       s_addr_o,
  output logic [31:0]       s_data_o,
  input  logic [32*NS-1:0]  s_data_i,
  input  logic [NS-1:0]     s_ack_i,
  input  logic [NS-1:0]     s_err_i,
  output logic [NM-1:0]     gnt_o
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {IDLE, OWN, FAULT} state_t;

  state_t          r_state, w_next;
  logic [GW-1:0]   r_gnt, r_last, w_pick;
  logic [15:0]     r_cnt;
  logic            w_found;
  logic            w_cyc, w_stb, w_we;
  logic [3:0]      w_sel;
  logic [31:0]     w_addr, w_dat;
  logic [3:0]      w_idx;
  logic            w_hit, w_sack, w_serr, w_wait;

  // Round-robin pick: first requester searching upward from last_gnt+1
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= NM; k++)
      for (int m = 0; m < NM; m++)
        if (!w_found && m_cyc_i[m] && (m == (int'(r_last) + k) % NM)) begin
          w_pick  = GW'(m);
          w_found = 1'b1;
        end
  end

  // Granted master's bus signals; everything reads as zero while idle
  always_comb begin
    w_cyc  = 1'b0;
    w_stb  = 1'b0;
    w_we   = 1'b0;
    w_sel  = '0;
    w_addr = '0;
    w_dat  = '0;
    gnt_o  = '0;
    if (r_state != IDLE)
      for (int m = 0; m < NM; m++)
        if (r_gnt == GW'(m)) begin
          w_cyc    = m_cyc_i[m];
          w_stb    = m_stb_i[m];
          w_we     = m_we_i[m];
          w_sel    = m_sel_i[4*m +: 4];
          w_addr   = m_addr_i[32*m +: 32];
          w_dat    = m_data_i[32*m +: 32];
          gnt_o[m] = 1'b1;
        end
  end

  assign s_we_o   = w_we;
  assign s_sel_o  = w_sel;
  assign s_addr_o = w_addr;
  assign s_data_o = w_dat;
  assign w_idx    = w_addr[31:28];

  // Slave decode and return path; only live in OWN, out-of-range index hits nothing
  always_comb begin
    s_cyc_o  = '0;
    s_stb_o  = '0;
    m_data_o = '0;
    w_hit    = 1'b0;
    w_sack   = 1'b0;
    w_serr   = 1'b0;
    if (r_state == OWN)
      for (int s = 0; s < NS; s++)
        if (int'(w_idx) == s) begin
          s_cyc_o[s] = w_cyc;
          s_stb_o[s] = w_stb;
          m_data_o   = s_data_i[32*s +: 32];
          w_sack     = s_ack_i[s];
          w_serr     = s_err_i[s];
          w_hit      = 1'b1;
        end
  end

  // A strobed access still waiting on its slave
  assign w_wait = w_hit && w_stb && !w_sack && !w_serr;

  // Ack/err go only to the granted master; FAULT injects the error pulse
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    if (r_state != IDLE)
      for (int m = 0; m < NM; m++)
        if (r_gnt == GW'(m)) begin
          m_ack_o[m] = w_sack;
          m_err_o[m] = w_serr || (r_state == FAULT);
        end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|m_cyc_i) w_next = OWN;
      OWN: begin
        if (!w_cyc)                               w_next = IDLE;
        else if (w_stb && !w_hit)                 w_next = FAULT;
        else if (w_wait && r_cnt == 16'(TO - 1))  w_next = FAULT;
      end
      FAULT:   w_next = w_cyc ? OWN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Grant, fairness pointer and watchdog counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt  <= '0;
      r_last <= GW'(NM - 1);
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (|m_cyc_i) r_gnt <= w_pick;
        end
        OWN: begin
          if (!w_cyc)              r_last <= r_gnt;
          if (w_sack || w_serr)    r_cnt  <= '0;
          else if (w_wait)         r_cnt  <= r_cnt + 16'd1;
        end
        default: begin
          r_cnt <= '0;
          if (!w_cyc) r_last <= r_gnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Directed bench for wb_rr_intercon: routing vector table plus hand-written
// sequences for arbitration order, decode fault, timeout and async reset.
module tb_wb_rr_intercon;
  localparam int NM = 4;
  localparam int NS = 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
  logic [4*NM-1:0]   m_sel_i;
  logic [32*NM-1:0]  m_addr_i, m_data_i;
  logic [31:0]       m_data_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic              s_we_o;
  logic [3:0]        s_sel_o;
  logic [31:0]       s_addr_o, s_data_o;
  logic [32*NS-1:0]  s_data_i;
  logic [NS-1:0]     s_ack_i, s_err_i;
  logic [NM-1:0]     gnt_o;

  always #5 clk = ~clk;

  wb_rr_intercon #(.NM(NM), .NS(NS), .TO(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        stb;
    logic [7:0]  ack, err;
    logic [31:0] sdat;
    logic [7:0]  e_cyc, e_stb;
    logic [3:0]  e_ack, e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tv [6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_sdat(input logic [3:0] idx, input logic [31:0] d);
    for (int s = 0; s < NS; s++)
      s_data_i[32*s +: 32] = (int'(idx) == s) ? d : (32'hC0DE_0000 + 32'(s));
  endtask

  initial begin
    tv[0] = '{32'h3000_0010, 1'b1, 8'h08, 8'h00, 32'hDEAD_BEEF, 8'h08, 8'h08, 4'b0001, 4'b0000, 32'hDEAD_BEEF};
    tv[1] = '{32'h0000_0004, 1'b1, 8'h01, 8'h00, 32'h0BAD_F00D, 8'h01, 8'h01, 4'b0001, 4'b0000, 32'h0BAD_F00D};
    tv[2] = '{32'h7000_0000, 1'b1, 8'h80, 8'h00, 32'h1234_5678, 8'h80, 8'h80, 4'b0001, 4'b0000, 32'h1234_5678};
    tv[3] = '{32'h3000_0000, 1'b1, 8'h04, 8'h08, 32'hCAFE_0003, 8'h08, 8'h08, 4'b0000, 4'b0001, 32'hCAFE_0003};
    tv[4] = '{32'h5000_0000, 1'b0, 8'h00, 8'h00, 32'h5555_AAAA, 8'h20, 8'h00, 4'b0000, 4'b0000, 32'h5555_AAAA};
    tv[5] = '{32'h1000_0000, 1'b1, 8'h06, 8'h00, 32'h0000_0001, 8'h02, 8'h02, 4'b0001, 4'b0000, 32'h0000_0001};

    rst = 1'b0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '1;
    m_addr_i = '0; m_data_i = '0; s_ack_i = '0; s_err_i = '0;
    load_sdat(4'd0, 32'h0);

    // reset state
    #12;
    chk("rst gnt", 32'(gnt_o), 32'h0);
    chk("rst s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst s_stb", 32'(s_stb_o), 32'h0);
    chk("rst m_ack", 32'(m_ack_o), 32'h0);
    chk("rst m_err", 32'(m_err_o), 32'h0);
    chk("rst m_data", m_data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // first grant after reset goes to lowest requester, then round robin
    m_cyc_i = 4'b1010;
    #1 chk("arb idle gnt", 32'(gnt_o), 32'h0);
    tick;
    chk("arb first gnt", 32'(gnt_o), 32'h2);
    m_cyc_i = 4'b1000;
    tick;
    chk("arb release idle", 32'(gnt_o), 32'h0);
    chk("arb idle s_cyc", 32'(s_cyc_o), 32'h0);
    tick;
    chk("arb second gnt", 32'(gnt_o), 32'h8);
    m_cyc_i = 4'b0000;
    tick;
    chk("arb all idle", 32'(gnt_o), 32'h0);

    // all four request; grant order 0,1,2,3,0 with an idle gap each time
    m_cyc_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("rr gnt %0d", i), 32'(gnt_o), 32'(1 << (i % 4)));
      if (i < 4) begin
        m_cyc_i[i % 4] = 1'b0;
        tick;
        chk($sformatf("rr gap %0d", i), 32'(gnt_o), 32'h0);
        m_cyc_i[i % 4] = 1'b1;
      end
    end

    // master 0 holds the bus; master 1 requests and strobes but must be ignored
    m_cyc_i = 4'b0011;
    m_stb_i[1] = 1'b1;
    m_addr_i[63:32] = 32'h2000_0000;
    for (int v = 0; v < 6; v++) begin
      m_addr_i[31:0] = tv[v].addr;
      m_stb_i[0]     = tv[v].stb;
      s_ack_i        = tv[v].ack;
      s_err_i        = tv[v].err;
      load_sdat(tv[v].addr[31:28], tv[v].sdat);
      #1;
      chk($sformatf("v%0d gnt", v), 32'(gnt_o), 32'h1);
      chk($sformatf("v%0d s_cyc", v), 32'(s_cyc_o), 32'(tv[v].e_cyc));
      chk($sformatf("v%0d s_stb", v), 32'(s_stb_o), 32'(tv[v].e_stb));
      chk($sformatf("v%0d m_ack", v), 32'(m_ack_o), 32'(tv[v].e_ack));
      chk($sformatf("v%0d m_err", v), 32'(m_err_o), 32'(tv[v].e_err));
      chk($sformatf("v%0d m_data", v), m_data_o, tv[v].e_dat);
      chk($sformatf("v%0d s_addr", v), s_addr_o, tv[v].addr);
      tick;
    end

    // slave 1 never answers: four waiting cycles then a one-cycle error
    m_stb_i[1] = 1'b0;
    m_addr_i[31:0] = 32'h1000_0000;
    m_stb_i[0] = 1'b1;
    s_ack_i = '0;
    s_err_i = '0;
    for (int w = 0; w < TO; w++) begin
      #1;
      chk($sformatf("to wait%0d s_stb", w), 32'(s_stb_o), 32'h02);
      chk($sformatf("to wait%0d m_err", w), 32'(m_err_o), 32'h0);
      tick;
    end
    chk("to fault m_err", 32'(m_err_o), 32'h1);
    chk("to fault s_cyc", 32'(s_cyc_o), 32'h0);
    chk("to fault s_stb", 32'(s_stb_o), 32'h0);
    tick;
    chk("to back m_err", 32'(m_err_o), 32'h0);
    chk("to back s_stb", 32'(s_stb_o), 32'h02);

    // master 2 strobes an unmapped slave index
    m_stb_i = '0;
    m_cyc_i = 4'b0100;
    m_addr_i[95:64] = 32'hA000_0000;
    m_stb_i[2] = 1'b1;
    tick;
    chk("dec release", 32'(gnt_o), 32'h0);
    tick;
    chk("dec gnt", 32'(gnt_o), 32'h4);
    chk("dec s_stb", 32'(s_stb_o), 32'h0);
    chk("dec s_cyc", 32'(s_cyc_o), 32'h0);
    chk("dec m_err early", 32'(m_err_o), 32'h0);
    chk("dec m_data", m_data_o, 32'h0);
    tick;
    chk("dec m_err", 32'(m_err_o), 32'h4);
    m_stb_i[2] = 1'b0;
    tick;
    chk("dec m_err once", 32'(m_err_o), 32'h0);

    // reset in the middle of master 1's write to slave 5
    m_cyc_i = 4'b0010;
    m_addr_i[63:32] = 32'h5000_0000;
    m_we_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    tick;
    tick;
    chk("wr gnt", 32'(gnt_o), 32'h2);
    chk("wr s_stb", 32'(s_stb_o), 32'h20);
    chk("wr s_cyc", 32'(s_cyc_o), 32'h20);
    chk("wr s_we", 32'(s_we_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid rst s_cyc", 32'(s_cyc_o), 32'h0);
    chk("mid rst s_stb", 32'(s_stb_o), 32'h0);
    chk("mid rst gnt", 32'(gnt_o), 32'h0);
    m_cyc_i = 4'b0011;
    tick;
    rst = 1'b1;
    tick;
    chk("post rst gnt", 32'(gnt_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
